// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage with load alignment, pending-write scoreboard, optional bypass (WB_BYPASS_EN)
module wb_stage #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic [1:0]      in_ld_size,
    input  logic            in_ld_signed,
    input  logic [1:0]      in_addr_lo,
    input  logic [DW-1:0]   in_alu_result,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            wb_we,
    output logic [4:0]      wb_rina,
    output logic [DW-1:0]   wb_din,
    output logic [NREG-1:0] busy,
    output logic            byp_valid,
    output logic [4:0]      byp_rd,
    output logic [DW-1:0]   byp_data
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_WAIT_MEM = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rina_q, wb_rina_d;
    logic [DW-1:0]   wb_din_q, wb_din_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            ld_we_q, ld_we_d;
    logic [1:0]      ld_size_q, ld_size_d;
    logic            ld_signed_q, ld_signed_d;
    logic [1:0]      ld_addr_q, ld_addr_d;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [DW-1:0]   ld_ext;
    logic            accept;

    assign in_ready = (state_q != S_WAIT_MEM);
    assign accept   = in_valid && in_ready;
    assign wb_we    = wb_we_q;
    assign wb_rina  = wb_rina_q;
    assign wb_din   = wb_din_q;
    assign busy     = busy_q;

    // Select the addressed lane of the returned word and extend it to full width
    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_ext  = mem_rdata;
        case (ld_addr_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ld_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_size_q)
            2'b00:   ld_ext = ld_signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h000000, ld_byte};
            2'b01:   ld_ext = ld_signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0000, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state logic: accept entries, park loads until data returns, produce one write per retire
    always_comb begin
        state_d     = state_q;
        wb_we_d     = 1'b0;
        wb_rina_d   = wb_rina_q;
        wb_din_d    = wb_din_q;
        ld_rd_d     = ld_rd_q;
        ld_we_d     = ld_we_q;
        ld_size_d   = ld_size_q;
        ld_signed_d = ld_signed_q;
        ld_addr_d   = ld_addr_q;
        case (state_q)
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    wb_we_d   = ld_we_q && (ld_rd_q != 5'd0);
                    wb_rina_d = ld_rd_q;
                    wb_din_d  = ld_ext;
                    state_d   = S_WRITE;
                end
            end
            default: begin
                if (accept) begin
                    if (in_is_load) begin
                        ld_rd_d     = in_rd;
                        ld_we_d     = in_reg_write;
                        ld_size_d   = in_ld_size;
                        ld_signed_d = in_ld_signed;
                        ld_addr_d   = in_addr_lo;
                        state_d     = S_WAIT_MEM;
                    end else begin
                        wb_we_d   = in_reg_write && (in_rd != 5'd0);
                        wb_rina_d = in_rd;
                        wb_din_d  = in_alu_result;
                        state_d   = S_WRITE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Scoreboard: retire the register being written, then mark the newly issued one (newer wins)
    always_comb begin
        busy_d = busy_q;
        if (wb_we_q) begin
            busy_d[wb_rina_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State and output registers; reset drops any pending load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wb_we_q     <= 1'b0;
            wb_rina_q   <= 5'd0;
            wb_din_q    <= '0;
            busy_q      <= '0;
            ld_rd_q     <= 5'd0;
            ld_we_q     <= 1'b0;
            ld_size_q   <= 2'b00;
            ld_signed_q <= 1'b0;
            ld_addr_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            wb_we_q     <= wb_we_d;
            wb_rina_q   <= wb_rina_d;
            wb_din_q    <= wb_din_d;
            busy_q      <= busy_d;
            ld_rd_q     <= ld_rd_d;
            ld_we_q     <= ld_we_d;
            ld_size_q   <= ld_size_d;
            ld_signed_q <= ld_signed_d;
            ld_addr_q   <= ld_addr_d;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid = wb_we_q;
    assign byp_rd    = wb_rina_q;
    assign byp_data  = wb_din_q;
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = 5'd0;
    assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed table-driven bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_signed;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        wb_we;
    logic [4:0]  wb_rina;
    logic [31:0] wb_din;
    logic [31:0] busy;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;

    int n_total = 0;
    int n_pass  = 0;

    logic [4:0]  last_rina;
    logic [31:0] last_din;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
        .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wb_we(wb_we), .wb_rina(wb_rina), .wb_din(wb_din), .busy(busy),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
    );

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic        iv;
        logic [4:0]  ird;
        logic        ewe;
        logic [4:0]  erina;
        logic [31:0] edin;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [4:0] rd, logic rw, logic [31:0] alu,
                                logic iv, logic [4:0] ird, logic ewe, logic [4:0] erina,
                                logic [31:0] edin, logic [31:0] ebusy);
        vec_t t;
        t.rst_n = r; t.v = v; t.rd = rd; t.rw = rw; t.alu = alu;
        t.iv = iv; t.ird = ird; t.ewe = ewe; t.erina = erina; t.edin = edin; t.ebusy = ebusy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    task automatic chk_outs(input string tag, input logic ewe, input logic [4:0] erina,
                            input logic [31:0] edin, input logic [31:0] ebusy, input logic erdy);
        chk({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, ewe});
        chk({tag, ".wb_rina"}, {27'd0, wb_rina}, {27'd0, erina});
        chk({tag, ".wb_din"}, wb_din, edin);
        chk({tag, ".busy"}, busy, ebusy);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, erdy});
`ifdef WB_BYPASS_EN
        chk({tag, ".byp_valid"}, {31'd0, byp_valid}, {31'd0, ewe});
        chk({tag, ".byp_rd"}, {27'd0, byp_rd}, {27'd0, erina});
        chk({tag, ".byp_data"}, byp_data, edin);
`else
        chk({tag, ".byp_valid"}, {31'd0, byp_valid}, 32'd0);
        chk({tag, ".byp_rd"}, {27'd0, byp_rd}, 32'd0);
        chk({tag, ".byp_data"}, byp_data, 32'd0);
`endif
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rd = 0; in_reg_write = 0; in_is_load = 0; in_ld_size = 0;
        in_ld_signed = 0; in_addr_lo = 0; in_alu_result = 0; mem_rvalid = 0;
        mem_rdata = 0; iss_valid = 0; iss_rd = 0;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Load with 3 idle wait cycles; mem_rvalid pulses at acceptance and must be ignored
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [1:0] size,
                           input logic sgn, input logic [1:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp);
        int not_ready;
        not_ready = 0;
        @(negedge clk);
        idle_inputs();
        rst_n = 1; in_valid = 1; in_is_load = 1; in_rd = rd; in_reg_write = 1;
        in_ld_size = size; in_ld_signed = sgn; in_addr_lo = addr; in_alu_result = 32'hCAFE0000;
        mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5;
        sample();
        if (!in_ready) not_ready++;
        chk_outs({tag, ".accept"}, 1'b0, last_rina, last_din, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            sample();
            if (!in_ready) not_ready++;
            chk({tag, ".wait_we"}, {31'd0, wb_we}, 32'd0);
        end
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = rdata;
        sample();
        chk({tag, ".not_ready_cycles"}, not_ready, 32'd4);
        chk_outs({tag, ".write"}, 1'b1, rd, exp, 32'd0, 1'b1);
        @(negedge clk);
        idle_inputs();
        sample();
        chk_outs({tag, ".after"}, 1'b0, rd, exp, 32'd0, 1'b1);
        last_rina = rd;
        last_din  = exp;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        last_rina = 0;
        last_din  = 0;

        //                r  v  rd  rw alu            iv ird  we rina din            busy
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,         0, 0,   0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         0, 0,   0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 5,  1, 32'hDEADBEEF,  0, 0,   1, 5, 32'hDEADBEEF,  32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         0, 0,   0, 5, 32'hDEADBEEF,  32'h0));
        vecs.push_back(mk(1, 1, 0,  1, 32'h1234,      0, 0,   0, 0, 32'h1234,      32'h0));
        vecs.push_back(mk(1, 1, 9,  0, 32'h1234,      0, 0,   0, 9, 32'h1234,      32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         0, 0,   0, 9, 32'h1234,      32'h0));
        vecs.push_back(mk(1, 1, 1,  1, 32'h11111111,  0, 0,   1, 1, 32'h11111111,  32'h0));
        vecs.push_back(mk(1, 1, 2,  1, 32'h22222222,  0, 0,   1, 2, 32'h22222222,  32'h0));
        vecs.push_back(mk(1, 1, 3,  1, 32'h33333333,  0, 0,   1, 3, 32'h33333333,  32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         0, 0,   0, 3, 32'h33333333,  32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         1, 7,   0, 3, 32'h33333333,  32'h80));
        vecs.push_back(mk(1, 1, 7,  1, 32'h77,        0, 0,   1, 7, 32'h77,        32'h80));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         0, 0,   0, 7, 32'h77,        32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         1, 7,   0, 7, 32'h77,        32'h80));
        vecs.push_back(mk(1, 1, 7,  1, 32'h78,        0, 0,   1, 7, 32'h78,        32'h80));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         1, 7,   0, 7, 32'h78,        32'h80));
        vecs.push_back(mk(1, 1, 7,  1, 32'h79,        1, 0,   1, 7, 32'h79,        32'h80));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         0, 0,   0, 7, 32'h79,        32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         1, 3,   0, 7, 32'h79,        32'h8));
        vecs.push_back(mk(1, 1, 3,  1, 32'hAA,        1, 4,   1, 3, 32'hAA,        32'h18));
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,         0, 0,   0, 3, 32'hAA,        32'h10));
        vecs.push_back(mk(1, 1, 4,  0, 32'hBB,        0, 0,   0, 4, 32'hBB,        32'h10));
        vecs.push_back(mk(0, 1, 4,  1, 32'hBB,        1, 5,   0, 0, 32'h0,         32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            idle_inputs();
            rst_n         = vecs[i].rst_n;
            in_valid      = vecs[i].v;
            in_rd         = vecs[i].rd;
            in_reg_write  = vecs[i].rw;
            in_alu_result = vecs[i].alu;
            iss_valid     = vecs[i].iv;
            iss_rd        = vecs[i].ird;
            sample();
            chk_outs($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].erina, vecs[i].edin,
                     vecs[i].ebusy, 1'b1);
        end

        do_load("ld_b_s3", 5'd10, 2'b00, 1'b1, 2'd3, 32'h80FF0000, 32'hFFFFFF80);
        do_load("ld_h_u2", 5'd11, 2'b01, 1'b0, 2'd2, 32'h80FF0000, 32'h000080FF);
        do_load("ld_b_u1", 5'd12, 2'b00, 1'b0, 2'd1, 32'h11223344, 32'h00000033);
        do_load("ld_h_s3", 5'd13, 2'b01, 1'b1, 2'd3, 32'h80FF0000, 32'hFFFF80FF);
        do_load("ld_h_s0", 5'd14, 2'b01, 1'b1, 2'd0, 32'h12348001, 32'hFFFF8001);
        do_load("ld_w_1",  5'd15, 2'b10, 1'b1, 2'd1, 32'h89ABCDEF, 32'h89ABCDEF);
        do_load("ld_w_11", 5'd16, 2'b11, 1'b0, 2'd2, 32'h0BADF00D, 32'h0BADF00D);

        // Reset while a load is pending; a late mem_rvalid must not produce a write
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_is_load = 1; in_rd = 6; in_reg_write = 1; in_ld_size = 2'b10;
        iss_valid = 1; iss_rd = 6;
        sample();
        chk_outs("rst_wait.accept", 1'b0, last_rina, last_din, 32'h40, 1'b0);
        @(negedge clk);
        idle_inputs();
        sample();
        chk_outs("rst_wait.hold", 1'b0, last_rina, last_din, 32'h40, 1'b0);
        @(negedge clk);
        rst_n = 0;
        sample();
        chk_outs("rst_wait.reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h55667788;
        sample();
        chk_outs("rst_wait.late_rvalid", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        idle_inputs();
        sample();
        chk_outs("rst_wait.after", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
